dqs_write_sequencer: RTL and testbench
======================================

// Module: dqs_write_sequencer
// PURPOSE
//  Sequences the DQS strobe for one DDR write burst. Sits directly upstream of the DQS
//  pad stage and drives its ODDRD1/ODDRD2 pattern and preDQSenL tristate enable.
//  Also emits a DQ-pad enable and a one-cycle-early data pull toward the write-data FIFO.
//  Inserts preamble, toggling burst and postamble at a fixed write latency after command accept.
// PARAMETERS
//  WL        2  MCLK cycles from accept edge to preamble cycle; legal 1..15
//  BL_WIDTH  4  width of burstLen; burst length in MCLK cycles (2 DDR beats each)
// PORTS
//  MCLK       in   1         memory clock; all logic on rising edge
//  Reset      in   1         synchronous reset, active high
//  wrReq      in   1         write burst request; held until wrAck
//  wrAck      out  1         accept; transfer occurs on edge where wrReq && wrAck
//  burstLen   in   BL_WIDTH  burst length in MCLK cycles, sampled at accept; 0 = 2**BL_WIDTH
//  ODDRD1     out  1         DQS value for first half of the next pad cycle
//  ODDRD2     out  1         DQS value for second half of the next pad cycle
//  preDQSenL  out  1         DQS tristate, active low (0 = drive)
//  preDQenL   out  1         DQ tristate, active low (0 = drive)
//  dataReq    out  1         pop one data word from write FIFO this cycle
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  - Every output is driven from a flop; there is no combinational input->output path.
//  - Reset (any state, mid-burst included): next cycle state=IDLE, wrAck=1,
//    ODDRD1=ODDRD2=0, preDQSenL=1, preDQenL=1, dataReq=0, busy=0. Burst is abandoned.
//  - States: IDLE, WAIT, PRE, BURST, POST.
//  - wrAck = (state==IDLE). One command in flight at a time; no seamless bursts.
//  - Cycle n = n-th cycle after the accept edge E0:
//    WAIT   cycles 1..WL-1; skipped entirely when WL==1. Outputs idle.
//    PRE    cycle WL: preDQSenL=0, D1=0, D2=0 (preamble low), preDQenL=1, dataReq=1.
//    BURST  cycles WL+1..WL+N: preDQSenL=0, preDQenL=0, D1=1, D2=0.
//           dataReq=1 in cycles WL+1..WL+N-1 and 0 in the last burst cycle.
//    POST   cycle WL+N+1: preDQSenL=0, D1=0, D2=0, preDQenL=1, dataReq=0.
//    IDLE   from cycle WL+N+2: preDQSenL=1, wrAck=1.
//  - Here N = burstLen, or 2**BL_WIDTH when burstLen==0.
//  - dataReq pulse count per burst is exactly N. It runs one cycle ahead of the matching
//    BURST cycle, covering cycles WL..WL+N-1.
//  - Counters: WAIT counter is ceil(log2(WL)) bits. Burst counter is BL_WIDTH+1 bits,
//    loaded with N and decremented each BURST cycle; it must not wrap.
//  - wrReq while busy is ignored; it is held and accepted at the first IDLE edge.
//  - burstLen changes after accept have no effect on the current burst.
// TESTING
//  1. WL=2, burstLen=4, accept at E0 -> PRE cycle 2, BURST 3..6, POST 7.
//     dataReq high 2..5; wrAck high again cycle 8.
//  2. WL=1, burstLen=1 -> no WAIT. PRE cycle 1, BURST 2 with D1=1/D2=0, POST 3.
//     Exactly one dataReq pulse, in cycle 1.
//  3. burstLen=0, BL_WIDTH=4 -> 16 BURST cycles, 16 dataReq pulses, no counter wrap.
//  4. wrReq held high continuously -> gap of exactly one IDLE cycle between bursts.
//     preDQSenL=1 in that cycle.
//  5. Reset asserted in 2nd BURST cycle -> next cycle preDQSenL=1, preDQenL=1,
//     dataReq=0, wrAck=1. A new request then completes normally.
//  6. wrReq asserted during POST -> no accept until IDLE. burstLen is sampled at the accept edge.

Source files
------------

// File: rtl/dqs_write_sequencer.sv
// dqs_write_sequencer: sequences the DQS strobe for one DDR write burst.
// After each accepted request it inserts a wait of WL-1 cycles, then a
// preamble, N toggling burst cycles and a postamble. The DQS pad pattern,
// the DQS/DQ tristates and a one-cycle-early write-FIFO pop are all
// generated here.
//
// Ports
//   MCLK       memory clock, all logic on the rising edge
//   Reset      synchronous reset, active high
//   wrReq      write burst request, held until wrAck
//   wrAck      accept; a transfer occurs on the edge where wrReq && wrAck
//   burstLen   burst length in MCLK cycles, sampled at accept; 0 = 2**BL_WIDTH
//   ODDRD1     DQS value for the first half of the next pad cycle
//   ODDRD2     DQS value for the second half of the next pad cycle
//   preDQSenL  DQS tristate, active low
//   preDQenL   DQ tristate, active low
//   dataReq    pop one word from the write FIFO this cycle
//   busy       high whenever the sequencer is not idle
module dqs_write_sequencer #(
  parameter int unsigned WL       = 2,
  parameter int unsigned BL_WIDTH = 4
) (
  input  logic                MCLK,
  input  logic                Reset,
  input  logic                wrReq,
  output logic                wrAck,
  input  logic [BL_WIDTH-1:0] burstLen,
  output logic                ODDRD1,
  output logic                ODDRD2,
  output logic                preDQSenL,
  output logic                preDQenL,
  output logic                dataReq,
  output logic                busy
);

  localparam int unsigned WAIT_W = (WL > 1) ? $clog2(WL) : 1;
  localparam int unsigned CNT_W  = BL_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PRE   = 3'd2,
    S_BURST = 3'd3,
    S_POST  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_n;

  logic ack_d, d1_d, dqsen_d, dqen_d, dreq_d, busy_d;

  // Burst length field 0 encodes the maximum length 2**BL_WIDTH.
  assign len_n = (burstLen == '0) ? {1'b1, {BL_WIDTH{1'b0}}} : {1'b0, burstLen};

  // Next state and next-cycle output values; outputs are registered from these.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (wrReq) begin
          cnt_d = len_n;
          if (WL == 1) begin
            state_d = S_PRE;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_W'(WL - 2);
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_PRE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_PRE: begin
        state_d = S_BURST;
      end
      S_BURST: begin
        // Counter reaches 0 only on the transition to POST, so it never wraps.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_POST;
      end
      S_POST: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d   = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    d1_d    = (state_d == S_BURST);
    dqsen_d = !((state_d == S_PRE) || (state_d == S_BURST) || (state_d == S_POST));
    dqen_d  = (state_d != S_BURST);
    // FIFO pop leads the burst by one cycle: high in PRE and in every BURST
    // cycle except the last one (counter value 1).
    dreq_d  = (state_d == S_PRE) || ((state_d == S_BURST) && (cnt_d != CNT_W'(1)));
  end

  // State, counters and registered outputs.
  always_ff @(posedge MCLK) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      wrAck     <= 1'b1;
      ODDRD1    <= 1'b0;
      ODDRD2    <= 1'b0;
      preDQSenL <= 1'b1;
      preDQenL  <= 1'b1;
      dataReq   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      wrAck     <= ack_d;
      ODDRD1    <= d1_d;
      ODDRD2    <= 1'b0;
      preDQSenL <= dqsen_d;
      preDQenL  <= dqen_d;
      dataReq   <= dreq_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_dqs_write_sequencer.sv
// Testbench for dqs_write_sequencer: two instances (WL=2 and WL=1) checked
// cycle by cycle against a cycle-index model of the write burst timeline.
module tb_dqs_write_sequencer;

  localparam int unsigned BLW = 4;
  localparam int          WLA = 2;
  localparam int          WLB = 1;
  localparam logic [6:0]  IDLE_V = 7'b1001100;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic           Reset;
  logic           req_a, req_b;
  logic [BLW-1:0] len_a, len_b;
  logic ack_a, d1_a, d2_a, dqs_a, dq_a, dr_a, busy_a;
  logic ack_b, d1_b, d2_b, dqs_b, dq_b, dr_b, busy_b;

  int checks = 0;
  int errors = 0;

  dqs_write_sequencer #(.WL(WLA), .BL_WIDTH(BLW)) dut_a (
    .MCLK(MCLK), .Reset(Reset), .wrReq(req_a), .wrAck(ack_a), .burstLen(len_a),
    .ODDRD1(d1_a), .ODDRD2(d2_a), .preDQSenL(dqs_a), .preDQenL(dq_a),
    .dataReq(dr_a), .busy(busy_a)
  );

  dqs_write_sequencer #(.WL(WLB), .BL_WIDTH(BLW)) dut_b (
    .MCLK(MCLK), .Reset(Reset), .wrReq(req_b), .wrAck(ack_b), .burstLen(len_b),
    .ODDRD1(d1_b), .ODDRD2(d2_b), .preDQSenL(dqs_b), .preDQenL(dq_b),
    .dataReq(dr_b), .busy(busy_b)
  );

  // Observed outputs packed as {wrAck, D1, D2, preDQSenL, preDQenL, dataReq, busy}.
  function automatic logic [6:0] obs(input int which);
    if (which == 0) return {ack_a, d1_a, d2_a, dqs_a, dq_a, dr_a, busy_a};
    else            return {ack_b, d1_b, d2_b, dqs_b, dq_b, dr_b, busy_b};
  endfunction

  // Reference timeline: expected outputs in cycle c after the accept edge.
  function automatic logic [6:0] model(input int wl, input int n, input int c);
    if (c < wl)          return 7'b0001101;
    if (c == wl)         return 7'b0000111;
    if (c <= wl + n)     return {5'b01000, logic'(c < wl + n), 1'b1};
    if (c == wl + n + 1) return 7'b0000101;
    return IDLE_V;
  endfunction

  task automatic set_req(input int which, input logic r, input logic [BLW-1:0] l);
    if (which == 0) begin req_a = r; len_a = l; end
    else            begin req_b = r; len_b = l; end
  endtask

  // One burst on one instance; called and returns at a negedge.
  task automatic run_burst(input int which, input int blen, input bit hold,
                           input bit decoy, output int waits);
    int wl;
    int n;
    int pulses;
    logic [6:0] o;
    logic [6:0] e;
    wl = (which == 0) ? WLA : WLB;
    n  = (blen == 0) ? 16 : blen;
    waits = 0;
    set_req(which, 1'b1, BLW'(blen));
    o = obs(which);
    while (o[6] !== 1'b1 && waits < 50) begin
      @(negedge MCLK);
      waits++;
      o = obs(which);
    end
    checks++;
    if (waits >= 50) begin
      errors++;
      $display("FAIL accept_timeout dut=%0d waited=%0d cycles, required wrAck", which, waits);
      return;
    end
    @(posedge MCLK);
    #1;
    set_req(which, hold, BLW'($urandom));
    pulses = 0;
    for (int c = 1; c <= wl + n + 2; c++) begin
      @(negedge MCLK);
      o = obs(which);
      e = model(wl, n, c);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeline dut=%0d len=%0d cycle=%0d got=%b exp=%b", which, n, c, o, e);
      end
      if (o[1] === 1'b1) pulses++;
      if (decoy && c == wl + n + 1) set_req(which, 1'b1, BLW'($urandom));
    end
    checks++;
    if (pulses !== n) begin
      errors++;
      $display("FAIL datareq_count dut=%0d got=%0d exp=%0d", which, pulses, n);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs(w) !== IDLE_V) begin
        errors++;
        $display("FAIL %s dut=%0d got=%b exp=%b", tag, w, obs(w), IDLE_V);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (3) @(negedge MCLK);
    check_idle("reset_state");
    Reset = 1'b0;
    repeat (2) @(negedge MCLK);
    check_idle("idle_no_req");
  endtask

  task automatic test_basic();
    int w;
    run_burst(0, 4, 1'b0, 1'b0, w);
    run_burst(1, 1, 1'b0, 1'b0, w);
    run_burst(1, 4, 1'b0, 1'b0, w);
  endtask

  task automatic test_full_length();
    int w;
    run_burst(0, 0, 1'b0, 1'b0, w);
    run_burst(1, 0, 1'b0, 1'b0, w);
    run_burst(0, 15, 1'b0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        run_burst(d, int'($urandom_range(0, 15)), (i < 3), 1'b0, w);
        if (i > 0) begin
          checks++;
          if (w !== 0) begin
            errors++;
            $display("FAIL b2b_gap dut=%0d extra_wait=%0d exp=0", d, w);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int w;
    logic [6:0] o;
    logic [6:0] e;
    set_req(0, 1'b1, BLW'(6));
    @(posedge MCLK);
    #1;
    set_req(0, 1'b0, '0);
    for (int c = 1; c <= WLA + 2; c++) begin
      @(negedge MCLK);
      o = obs(0);
      e = model(WLA, 6, c);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pre_reset cycle=%0d got=%b exp=%b", c, o, e);
      end
    end
    Reset = 1'b1;
    @(negedge MCLK);
    Reset = 1'b0;
    check_idle("mid_burst_reset");
    run_burst(0, 3, 1'b0, 1'b0, w);
  endtask

  task automatic test_req_during_post();
    int w;
    run_burst(0, 5, 1'b0, 1'b1, w);
    run_burst(0, 9, 1'b0, 1'b0, w);
    run_burst(1, 2, 1'b0, 1'b1, w);
    run_burst(1, 7, 1'b0, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge MCLK);
      run_burst(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                1'b0, 1'b0, w);
    end
  endtask

  initial begin
    Reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    len_a = '0;   len_b = '0;
    @(negedge MCLK);
    test_reset();
    test_basic();
    test_full_length();
    test_back_to_back();
    test_mid_reset();
    test_req_during_post();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
